// File: rtl/line_card_port_config_pkg.sv
// Shared register map for the line card port configuration block.
// Offsets, global page index and VLAN_CFG bit positions feed software header generation.
package line_card_port_config_pkg;

    localparam int unsigned APB_DATA_W    = 32;
    localparam int unsigned PORT_IDX_W    = 5;
    localparam int unsigned REG_IDX_W     = 3;
    localparam int unsigned VLAN_ID_MAX_W = 12;
    localparam int unsigned GEN_W         = 16;

    localparam logic [PORT_IDX_W-1:0] GLOBAL_PAGE = 5'd31;

    // Per-port page
    localparam logic [REG_IDX_W-1:0] REG_VLAN_CFG   = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_DROP_COUNT = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_ACTIVE_CFG = 3'd2;

    // Global page
    localparam logic [REG_IDX_W-1:0] REG_COMMIT     = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_GENERATION = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_INFO       = 3'd2;

    localparam int unsigned VLAN_CFG_DROP_TAGGED_BIT   = 31;
    localparam int unsigned VLAN_CFG_DROP_UNTAGGED_BIT = 30;
    localparam int unsigned COMMIT_BIT                 = 0;

    typedef struct packed {
        logic                     drop_tagged;
        logic                     drop_untagged;
        logic [VLAN_ID_MAX_W-1:0] vlan;
    } port_cfg_t;

    function automatic logic [APB_DATA_W-1:0] pack_cfg(input port_cfg_t cfg);
        logic [APB_DATA_W-1:0] w;
        w                             = '0;
        w[VLAN_CFG_DROP_TAGGED_BIT]   = cfg.drop_tagged;
        w[VLAN_CFG_DROP_UNTAGGED_BIT] = cfg.drop_untagged;
        w[VLAN_ID_MAX_W-1:0]          = cfg.vlan;
        return w;
    endfunction

endpackage

// File: rtl/APB.sv
// APB register bus bundle; the block is a zero-wait-state completer.
interface APB #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  pclk;
    logic                  preset_n;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport completer (
        input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

    modport requester (
        input  pclk, preset_n, prdata, pready, pslverr,
        output psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/SatReadClearCounter.sv
// Saturating event counter with a clear that wins over the count but keeps a coincident event.
module SatReadClearCounter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = WIDTH'(inc);
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/line_card_port_config.sv
// Per-port VLAN / drop-policy configuration with shadow/active double buffering,
// atomic commit, generation counter and read-to-clear drop counters over APB.
module line_card_port_config
    import line_card_port_config_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 24,
    parameter int unsigned VLAN_WIDTH = 12,
    parameter int unsigned CTR_WIDTH  = 32
) (
    APB.completer                                apb,
    input  logic [NUM_PORTS-1:0]                 drop_event,
    output logic [NUM_PORTS-1:0][VLAN_WIDTH-1:0] port_vlan,
    output logic [NUM_PORTS-1:0]                 port_drop_tagged,
    output logic [NUM_PORTS-1:0]                 port_drop_untagged,
    output logic                                 config_updated
);

    if (NUM_PORTS < 1 || NUM_PORTS > 31) begin : g_bad_num_ports
        $error("NUM_PORTS must be within 1..31");
    end
    if (VLAN_WIDTH < 1 || VLAN_WIDTH > VLAN_ID_MAX_W) begin : g_bad_vlan_width
        $error("VLAN_WIDTH must be within 1..12");
    end
    if (CTR_WIDTH < 8 || CTR_WIDTH > 32) begin : g_bad_ctr_width
        $error("CTR_WIDTH must be within 8..32");
    end
    if ($bits(apb.prdata) != APB_DATA_W) begin : g_bad_data_width
        $error("APB DATA_WIDTH must be 32");
    end

    localparam logic [APB_DATA_W-1:0] INFO_WORD =
        {14'd0, 6'(CTR_WIDTH), 4'(VLAN_WIDTH), 8'(NUM_PORTS)};

    port_cfg_t             shadow_q [NUM_PORTS];
    port_cfg_t             active_q [NUM_PORTS];
    logic [GEN_W-1:0]      gen_q;
    logic                  config_updated_q;
    logic [CTR_WIDTH-1:0]  drop_count [NUM_PORTS];

    logic                  access_c;
    logic [PORT_IDX_W-1:0] port_c;
    logic [REG_IDX_W-1:0]  reg_c;
    logic                  global_c;
    logic                  port_ok_c;
    logic                  err_c;
    logic                  ok_c;
    logic                  shadow_we_c;
    logic                  commit_c;
    logic [NUM_PORTS-1:0]  clr_c;
    port_cfg_t             new_cfg_c;
    port_cfg_t             sel_shadow_c;
    port_cfg_t             sel_active_c;
    logic [CTR_WIDTH-1:0]  sel_count_c;
    logic [APB_DATA_W-1:0] rdata_c;
    logic                  unused_c;

    assign access_c  = apb.psel && apb.penable;
    assign port_c    = apb.paddr[9:5];
    assign reg_c     = apb.paddr[4:2];
    assign global_c  = (port_c == GLOBAL_PAGE);
    assign port_ok_c = (32'(port_c) < NUM_PORTS);
    assign unused_c  = ^{apb.paddr, apb.pwdata};

    // Error classification: bad page, undefined reg, write to RO, read of COMMIT
    always_comb begin
        err_c = 1'b0;
        if (global_c) begin
            case (reg_c)
                REG_COMMIT:               err_c = !apb.pwrite;
                REG_GENERATION, REG_INFO: err_c = apb.pwrite;
                default:                  err_c = 1'b1;
            endcase
        end else if (!port_ok_c) begin
            err_c = 1'b1;
        end else begin
            case (reg_c)
                REG_VLAN_CFG:                   err_c = 1'b0;
                REG_DROP_COUNT, REG_ACTIVE_CFG: err_c = apb.pwrite;
                default:                        err_c = 1'b1;
            endcase
        end
    end

    assign ok_c        = access_c && !err_c;
    assign shadow_we_c = ok_c && !global_c && apb.pwrite && (reg_c == REG_VLAN_CFG);
    assign commit_c    = ok_c && global_c && apb.pwrite && (reg_c == REG_COMMIT)
                         && apb.pwdata[COMMIT_BIT];

    always_comb begin
        new_cfg_c               = '0;
        new_cfg_c.drop_tagged   = apb.pwdata[VLAN_CFG_DROP_TAGGED_BIT];
        new_cfg_c.drop_untagged = apb.pwdata[VLAN_CFG_DROP_UNTAGGED_BIT];
        new_cfg_c.vlan          = VLAN_ID_MAX_W'(apb.pwdata[VLAN_WIDTH-1:0]);
    end

    always_comb begin
        sel_shadow_c = '0;
        sel_active_c = '0;
        sel_count_c  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_c == PORT_IDX_W'(i)) begin
                sel_shadow_c = shadow_q[i];
                sel_active_c = active_q[i];
                sel_count_c  = drop_count[i];
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        if (ok_c && !apb.pwrite) begin
            if (global_c) begin
                case (reg_c)
                    REG_GENERATION: rdata_c = APB_DATA_W'(gen_q);
                    REG_INFO:       rdata_c = INFO_WORD;
                    default:        rdata_c = '0;
                endcase
            end else begin
                case (reg_c)
                    REG_VLAN_CFG:   rdata_c = pack_cfg(sel_shadow_c);
                    REG_DROP_COUNT: rdata_c = APB_DATA_W'(sel_count_c);
                    REG_ACTIVE_CFG: rdata_c = pack_cfg(sel_active_c);
                    default:        rdata_c = '0;
                endcase
            end
        end
    end

    assign apb.pready  = access_c;
    assign apb.pslverr = access_c && err_c;
    assign apb.prdata  = rdata_c;

    // Shadow writes, atomic shadow->active copy and generation count
    always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
        if (!apb.preset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            gen_q            <= '0;
            config_updated_q <= 1'b0;
        end else begin
            config_updated_q <= commit_c;
            if (commit_c) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                gen_q <= gen_q + GEN_W'(1);
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (shadow_we_c && (port_c == PORT_IDX_W'(i))) begin
                    shadow_q[i] <= new_cfg_c;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign clr_c[g] = ok_c && !apb.pwrite && !global_c && (reg_c == REG_DROP_COUNT)
                          && (port_c == PORT_IDX_W'(g));

        SatReadClearCounter #(
            .WIDTH (CTR_WIDTH)
        ) u_drop_ctr (
            .clk   (apb.pclk),
            .rst_n (apb.preset_n),
            .inc   (drop_event[g]),
            .clr   (clr_c[g]),
            .count (drop_count[g])
        );

        assign port_vlan[g]          = active_q[g].vlan[VLAN_WIDTH-1:0];
        assign port_drop_tagged[g]   = active_q[g].drop_tagged;
        assign port_drop_untagged[g] = active_q[g].drop_untagged;
    end

    assign config_updated = config_updated_q;

endmodule

// File: tb/tb_line_card_port_config.sv
// Directed bench for line_card_port_config: a default-sized instance and a narrow
// (8 ports, 8-bit VLAN, 8-bit counters) instance sharing one clock and reset.
module tb_line_card_port_config;

    localparam int unsigned NP0 = 24;
    localparam int unsigned VW0 = 12;
    localparam int unsigned CW0 = 32;
    localparam int unsigned NP1 = 8;
    localparam int unsigned VW1 = 8;
    localparam int unsigned CW1 = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    APB #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus0 ();
    APB #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus1 ();

    assign bus0.pclk     = clk;
    assign bus0.preset_n = rst_n;
    assign bus1.pclk     = clk;
    assign bus1.preset_n = rst_n;

    logic [NP0-1:0]          drop0;
    logic [NP0-1:0][VW0-1:0] vlan0;
    logic [NP0-1:0]          dt0;
    logic [NP0-1:0]          du0;
    logic                    upd0;
    logic [NP1-1:0]          drop1;
    logic [NP1-1:0][VW1-1:0] vlan1;
    logic [NP1-1:0]          dt1;
    logic [NP1-1:0]          du1;
    logic                    upd1;

    line_card_port_config #(
        .NUM_PORTS (NP0), .VLAN_WIDTH (VW0), .CTR_WIDTH (CW0)
    ) u_dut0 (
        .apb                (bus0),
        .drop_event         (drop0),
        .port_vlan          (vlan0),
        .port_drop_tagged   (dt0),
        .port_drop_untagged (du0),
        .config_updated     (upd0)
    );

    line_card_port_config #(
        .NUM_PORTS (NP1), .VLAN_WIDTH (VW1), .CTR_WIDTH (CW1)
    ) u_dut1 (
        .apb                (bus1),
        .drop_event         (drop1),
        .port_vlan          (vlan1),
        .port_drop_tagged   (dt1),
        .port_drop_untagged (du1),
        .config_updated     (upd1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] a(input int port, input int r);
        logic [4:0] p5;
        logic [2:0] r3;
        p5 = 5'(port);
        r3 = 3'(r);
        return 12'({p5, r3, 2'b00});
    endfunction

    task automatic bus_drive(input int b, input logic sel, input logic en, input logic wr,
                             input logic [11:0] addr, input logic [31:0] wd);
        if (b == 0) begin
            bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr;
            bus0.paddr = addr; bus0.pwdata = wd;
        end else begin
            bus1.psel = sel; bus1.penable = en; bus1.pwrite = wr;
            bus1.paddr = addr; bus1.pwdata = wd;
        end
    endtask

    task automatic bus_sample(input int b, output logic [31:0] rd, output logic err,
                              output logic rdy);
        if (b == 0) begin
            rd = bus0.prdata; err = bus0.pslverr; rdy = bus0.pready;
        end else begin
            rd = bus1.prdata; err = bus1.pslverr; rdy = bus1.pready;
        end
    endtask

    // One APB transfer; entered and left 1 time unit after a rising edge
    task automatic xfer(input int b, input logic wr, input logic [11:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
        logic rdy;
        logic [31:0] rd_setup;
        logic err_setup;
        bus_drive(b, 1'b1, 1'b0, wr, addr, wd);
        #2;
        bus_sample(b, rd_setup, err_setup, rdy);
        chk("pready.setup", 32'(rdy), 32'd0);
        @(posedge clk); #1;
        bus_drive(b, 1'b1, 1'b1, wr, addr, wd);
        #3;
        bus_sample(b, rd, err, rdy);
        chk("pready.access", 32'(rdy), 32'd1);
        @(posedge clk); #1;
        bus_drive(b, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic wr_chk(input int b, input string tag, input logic [11:0] addr,
                          input logic [31:0] wd, input logic exp_err);
        logic [31:0] rd;
        logic err;
        xfer(b, 1'b1, addr, wd, rd, err);
        chk({tag, ".pslverr"}, 32'(err), 32'(exp_err));
    endtask

    task automatic rd_chk(input int b, input string tag, input logic [11:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic err;
        xfer(b, 1'b0, addr, 32'h0, rd, err);
        chk({tag, ".pslverr"}, 32'(err), 32'(exp_err));
        chk(tag, rd, exp_data);
    endtask

    initial begin
        logic [31:0] rd;
        logic err;
        logic rdy;

        rst_n = 1'b0;
        drop0 = '0;
        drop1 = '0;
        bus_drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        bus_drive(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        #2;
        chk("rst.vlan0", 32'(|vlan0), 32'd0);
        chk("rst.dt0",   32'(|dt0),   32'd0);
        chk("rst.du0",   32'(|du0),   32'd0);
        chk("rst.upd0",  32'(upd0),   32'd0);
        chk("rst.vlan1", 32'(|vlan1), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd_chk(0, "info0", a(31, 2), 32'h0002_0C18, 1'b0);
        rd_chk(1, "info1", a(31, 2), 32'h0000_8808, 1'b0);
        rd_chk(0, "gen0.init", a(31, 1), 32'h0, 1'b0);

        // Shadow write does not reach the outputs until commit
        wr_chk(0, "wr.p3", a(3, 0), 32'h8000_0064, 1'b0);
        chk("p3.vlan.pre", 32'(vlan0[3]), 32'h0);
        chk("p3.dt.pre", 32'(dt0[3]), 32'h0);
        rd_chk(0, "p3.active.pre", a(3, 2), 32'h0, 1'b0);
        rd_chk(0, "p3.shadow", a(3, 0), 32'h8000_0064, 1'b0);
        wr_chk(0, "commit1", a(31, 0), 32'h1, 1'b0);
        chk("commit1.upd", 32'(upd0), 32'd1);
        chk("commit1.vlan", 32'(vlan0[3]), 32'h064);
        chk("commit1.dt", 32'(dt0[3]), 32'd1);
        chk("commit1.du", 32'(du0[3]), 32'd0);
        @(posedge clk); #1;
        chk("commit1.upd.off", 32'(upd0), 32'd0);
        rd_chk(0, "gen0.1", a(31, 1), 32'h1, 1'b0);
        rd_chk(0, "p3.active", a(3, 2), 32'h8000_0064, 1'b0);

        // Back-to-back write then commit; reserved data bits are dropped
        wr_chk(0, "wr.p3b", a(3, 0), 32'h7000_FFFF, 1'b0);
        wr_chk(0, "commit2", a(31, 0), 32'h1, 1'b0);
        chk("commit2.vlan", 32'(vlan0[3]), 32'hFFF);
        chk("commit2.dt", 32'(dt0[3]), 32'd0);
        chk("commit2.du", 32'(du0[3]), 32'd1);
        rd_chk(0, "p3.shadow.b", a(3, 0), 32'h4000_0FFF, 1'b0);

        wr_chk(0, "commit0", a(31, 0), 32'h0, 1'b0);
        chk("commit0.upd", 32'(upd0), 32'd0);
        rd_chk(0, "gen0.2", a(31, 1), 32'h2, 1'b0);

        // Error responses and absence of side effects
        drop0 = NP0'(1);
        repeat (2) @(posedge clk);
        #1 drop0 = '0;
        rd_chk(0, "err.port24", a(24, 0), 32'h0, 1'b1);
        wr_chk(0, "err.wr.drop0", a(0, 1), 32'hFFFF, 1'b1);
        rd_chk(0, "drop0.kept", a(0, 1), 32'h2, 1'b0);
        rd_chk(0, "err.rd.commit", a(31, 0), 32'h0, 1'b1);
        rd_chk(0, "err.undef", a(1, 3), 32'h0, 1'b1);
        wr_chk(0, "err.wr.active", a(3, 2), 32'h0, 1'b1);
        rd_chk(0, "p3.shadow.kept", a(3, 0), 32'h4000_0FFF, 1'b0);
        wr_chk(0, "err.wr.gen", a(31, 1), 32'h0, 1'b1);
        rd_chk(0, "gen0.kept", a(31, 1), 32'h2, 1'b0);
        wr_chk(0, "err.port30", a(30, 0), 32'h1, 1'b1);
        rd_chk(0, "err.glob.undef", a(31, 5), 32'h0, 1'b1);
        rd_chk(1, "err.port8", a(8, 1), 32'h0, 1'b1);
        rd_chk(1, "d1.p7.drop", a(7, 1), 32'h0, 1'b0);

        // Narrow instance truncates VLAN to 8 bits
        wr_chk(1, "d1.wr.p1", a(1, 0), 32'h0000_0ABC, 1'b0);
        wr_chk(1, "d1.commit", a(31, 0), 32'h1, 1'b0);
        chk("d1.vlan1", 32'(vlan1[1]), 32'h0BC);
        chk("d1.upd", 32'(upd1), 32'd1);
        rd_chk(1, "d1.gen", a(31, 1), 32'h1, 1'b0);

        // Drop counting and read-to-clear
        drop0 = NP0'(1) << 5;
        repeat (10) @(posedge clk);
        #1 drop0 = '0;
        rd_chk(0, "drop5.10", a(5, 1), 32'd10, 1'b0);
        rd_chk(0, "drop5.clr", a(5, 1), 32'd0, 1'b0);
        drop0 = NP0'(1) << 5;
        repeat (3) @(posedge clk);
        #1 drop0 = '0;
        bus_drive(0, 1'b1, 1'b0, 1'b0, a(5, 1), 32'h0);
        @(posedge clk); #1;
        bus_drive(0, 1'b1, 1'b1, 1'b0, a(5, 1), 32'h0);
        drop0 = NP0'(1) << 5;
        #3;
        bus_sample(0, rd, err, rdy);
        chk("drop5.coinc", rd, 32'd3);
        @(posedge clk); #1;
        bus_drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        drop0 = '0;
        rd_chk(0, "drop5.after", a(5, 1), 32'd1, 1'b0);

        // Saturation on the 8-bit instance, no saturation on the 32-bit one
        drop0 = NP0'(1) << 7;
        drop1 = NP1'(1) << 2;
        repeat (300) @(posedge clk);
        #1;
        drop0 = '0;
        drop1 = '0;
        rd_chk(1, "d1.sat", a(2, 1), 32'd255, 1'b0);
        rd_chk(1, "d1.sat.clr", a(2, 1), 32'd0, 1'b0);
        rd_chk(0, "drop7.300", a(7, 1), 32'd300, 1'b0);

        // Generation wrap: commit on every cycle of a held access phase
        bus_drive(0, 1'b1, 1'b0, 1'b1, a(31, 0), 32'h1);
        @(posedge clk); #1;
        bus_drive(0, 1'b1, 1'b1, 1'b1, a(31, 0), 32'h1);
        repeat (65533) @(posedge clk);
        #1;
        bus_drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        rd_chk(0, "gen0.ffff", a(31, 1), 32'hFFFF, 1'b0);
        wr_chk(0, "commit.wrap", a(31, 0), 32'h1, 1'b0);
        rd_chk(0, "gen0.wrap", a(31, 1), 32'h0, 1'b0);

        // Reset mid-access clears everything without a clock edge
        drop0 = NP0'(1) << 5;
        repeat (2) @(posedge clk);
        #1 drop0 = '0;
        chk("pre.rst.vlan", 32'(vlan0[3]), 32'hFFF);
        bus_drive(0, 1'b1, 1'b0, 1'b1, a(3, 0), 32'h8000_0123);
        @(posedge clk); #1;
        bus_drive(0, 1'b1, 1'b1, 1'b1, a(3, 0), 32'h8000_0123);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.vlan0", 32'(|vlan0), 32'd0);
        chk("arst.du0", 32'(|du0), 32'd0);
        chk("arst.dt0", 32'(|dt0), 32'd0);
        chk("arst.upd0", 32'(upd0), 32'd0);
        chk("arst.vlan1", 32'(|vlan1), 32'd0);
        @(posedge clk); #1;
        bus_drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        rd_chk(0, "post.gen", a(31, 1), 32'h0, 1'b0);
        rd_chk(0, "post.shadow", a(3, 0), 32'h0, 1'b0);
        rd_chk(0, "post.active", a(3, 2), 32'h0, 1'b0);
        rd_chk(0, "post.drop5", a(5, 1), 32'h0, 1'b0);
        rd_chk(1, "post.d1.gen", a(31, 1), 32'h0, 1'b0);
        wr_chk(0, "post.wr", a(3, 0), 32'h8000_0123, 1'b0);
        wr_chk(0, "post.commit", a(31, 0), 32'h1, 1'b0);
        chk("post.vlan", 32'(vlan0[3]), 32'h123);
        chk("post.dt", 32'(dt0[3]), 32'd1);
        chk("post.upd", 32'(upd0), 32'd1);
        rd_chk(0, "post.gen1", a(31, 1), 32'h1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/line_card_port_config.md
LINE_CARD_PORT_CONFIG -- requirements
Module: line_card_port_config

Interface
REQ-001 Parameter NUM_PORTS, default 24, number of line card ports; the block SHALL reject values outside 1..31 at elaboration.
REQ-002 Parameter VLAN_WIDTH, default 12, port VLAN ID width; the block SHALL support 1..12.
REQ-003 Parameter CTR_WIDTH, default 32, drop counter width; the block SHALL support 8..32.
REQ-004 apb.pclk  input  1  the single clock; all logic SHALL be in this domain.
REQ-005 apb.preset_n  input  1  reset, asynchronous, active-low.
REQ-006 apb  APB.completer  DATA_WIDTH 32  register bus; the block SHALL fail elaboration if DATA_WIDTH != 32.
REQ-007 drop_event  input  [NUM_PORTS]  one-cycle pulse per dropped frame per port.
REQ-008 port_vlan  output  [NUM_PORTS][VLAN_WIDTH]  active VLAN ID per port.
REQ-009 port_drop_tagged, port_drop_untagged  output  [NUM_PORTS]  active drop policy per port.
REQ-010 config_updated  output  1  single-cycle pulse when active config changes.

Function
REQ-011 Address decode SHALL be port = paddr[9:5], reg = paddr[4:2]; port 31 is the global page.
REQ-012 Per-port regs: 0 VLAN_CFG (RW shadow: bit31 drop tagged, bit30 drop untagged, VLAN_WIDTH-1:0 VLAN), 1 DROP_COUNT (RO, read-to-clear), 2 ACTIVE_CFG (RO, same layout as VLAN_CFG, active copy).
REQ-013 Global regs: 0 COMMIT (WO, bit0=1 commits), 1 GENERATION (RO, 16-bit commit count), 2 INFO (RO, NUM_PORTS in 7:0, VLAN_WIDTH in 11:8, CTR_WIDTH in 17:12).
REQ-014 pready SHALL equal psel && penable (zero wait states); prdata unused bits SHALL read 0.
REQ-015 pslverr SHALL assert with pready for: port >= NUM_PORTS and != 31; undefined reg; write to RO reg; read of COMMIT. Errored accesses SHALL have no side effects.
REQ-016 Write to VLAN_CFG SHALL update shadow only, taking data from pwdata; outputs SHALL NOT change.
REQ-017 Write to COMMIT with bit0=1 SHALL copy every shadow to active on the next clock edge, atomically for all ports, pulse config_updated for exactly that one cycle, and increment GENERATION modulo 2^16.
REQ-018 COMMIT write with bit0=0 SHALL be accepted with no effect.
REQ-019 DROP_COUNT SHALL increment by 1 per drop_event cycle and saturate at 2^CTR_WIDTH-1.
REQ-020 A successful DROP_COUNT read SHALL return the pre-clear value and clear the counter on that edge; if drop_event for that port is simultaneous, the counter SHALL become 1.
REQ-021 A VLAN_CFG write to port N in the same cycle as a commit is impossible (single bus); back-to-back write then commit SHALL commit the newly written value.

Reset
REQ-022 On apb.preset_n low, shadow and active VLAN SHALL be 0, drop_tagged 0, drop_untagged 0, counters 0, GENERATION 0, config_updated 0, immediately and independent of the clock.
REQ-023 Reset asserted mid-access SHALL abort the access with no partial update; the first access after release SHALL behave normally.

Structure
REQ-024 Register offsets, global page index (31) and VLAN_CFG bit positions SHALL live in a shared fabric package for software header generation.
REQ-025 One sub-module SatReadClearCounter (parameter WIDTH; inputs inc, clr; output count) SHALL be instantiated per port.

Verification
REQ-026 Write VLAN_CFG port 3 = 0x8000_0064 -> port_vlan[3] stays 0 and ACTIVE_CFG reads 0; write COMMIT=1 -> next cycle port_vlan[3]=0x064, drop_tagged[3]=1, config_updated one cycle, GENERATION=1.
REQ-027 Read port 24 reg 0 with NUM_PORTS=24 -> pslverr=1, prdata=0; write DROP_COUNT port 0 -> pslverr=1, counter unchanged.
REQ-028 Pulse drop_event[5] 10 cycles -> DROP_COUNT port 5 reads 10, immediate re-read reads 0; read coincident with a pulse -> returns N, next read returns 1.
REQ-029 CTR_WIDTH=8, 300 drop_event pulses -> reads 255.
REQ-030 65536 commits -> GENERATION wraps to 0; assert preset_n low mid-sequence -> all outputs 0 asynchronously, GENERATION 0.
